// File: rtl/avr_serial_tx.sv
// rtl/avr_serial_tx.sv - Buffered UART transmitter toward the AVR serial port (avr_rx)
//
// Queues bytes from fabric logic in a small FIFO and sends them as 8N1 frames
// on tx, LSB first. The AVR's busy line (block) is honoured only between
// frames. A frame that has started always completes.
// Optional feature macro: AVR_SERIAL_TX_PARITY_EN adds an even-parity bit,
// giving 8E1 frames of 11 bits.
//
// Ports
//   clk       in   1          system clock, rising edge
//   rst_n     in   1          synchronous reset, active low
//   data      in   8          byte to queue
//   new_data  in   1          push strobe; accepted when new_data && ready
//   ready     out  1          FIFO not full
//   count     out  FIFO_AW+1  bytes queued, excluding the frame in flight
//   block     in   1          AVR busy, asynchronous; 1 = do not start a frame
//   tx        out  1          serial line to the AVR, idle high, registered
//   busy      out  1          bytes queued or a frame in flight

module avr_serial_tx #(
  parameter int CLK_PER_BIT = 100,
  parameter int FIFO_AW     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         data,
  input  logic               new_data,
  output logic               ready,
  output logic [FIFO_AW:0]   count,
  input  logic               block,
  output logic               tx,
  output logic               busy
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam int                 CW       = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0]      CNT_MAX  = CW'(CLK_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef AVR_SERIAL_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and pointers
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q,  count_d;
  logic               push, pop;
  logic [7:0]         head;

  // block synchronizer; resets to "busy" so nothing starts before it settles
  logic blk_s1_q, blk_s2_q;

  // Transmit engine
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q,    tx_d;
  logic          bit_done;
  logic          can_start;
`ifdef AVR_SERIAL_TX_PARITY_EN
  logic          par_q,   par_d;
`endif

  assign head      = mem_q[rd_ptr_q];
  // A full FIFO refuses pushes even when a pop lands in the same cycle.
  assign push      = new_data && (count_q != CNT_FULL);
  assign bit_done  = (cnt_q == CNT_MAX);
  assign can_start = (count_q != '0) && !blk_s2_q;

  assign ready = (count_q != CNT_FULL);
  assign count = count_q;
  assign busy  = (count_q != '0) || (state_q != S_IDLE);
  assign tx    = tx_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // tx_d is decoded from the current state, so the line trails the state by
  // one clock; every state still drives the line for exactly CLK_PER_BIT cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
`ifdef AVR_SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (can_start) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef AVR_SERIAL_TX_PARITY_EN
          par_d   = ^head;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d  = 1'b0;
        cnt_d = bit_done ? '0 : cnt_q + CW'(1);
        if (bit_done) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d  = shift_q[0];
        cnt_d = bit_done ? '0 : cnt_q + CW'(1);
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef AVR_SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef AVR_SERIAL_TX_PARITY_EN
      S_PARITY: begin
        tx_d  = par_q;
        cnt_d = bit_done ? '0 : cnt_q + CW'(1);
        if (bit_done) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        tx_d  = 1'b1;
        cnt_d = bit_done ? '0 : cnt_q + CW'(1);
        if (bit_done) begin
          // Chain straight into the next frame when allowed: no idle gap.
          if (can_start) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef AVR_SERIAL_TX_PARITY_EN
            par_d   = ^head;
`endif
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage is not reset; the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      blk_s1_q <= 1'b1;
      blk_s2_q <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef AVR_SERIAL_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      blk_s1_q <= block;
      blk_s2_q <= blk_s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef AVR_SERIAL_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_avr_serial_tx.sv
// tb/tb_avr_serial_tx.sv - Self-checking bench for avr_serial_tx

module tb_avr_serial_tx;

  localparam int CPB = 4;
  localparam int AW  = 3;
`ifdef AVR_SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          new_data = 1'b0;
  logic          ready;
  logic [AW:0]   count;
  logic          block = 1'b0;
  logic          tx;
  logic          busy;

  avr_serial_tx #(.CLK_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .new_data(new_data), .ready(ready),
    .count(count), .block(block), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] b;
    int         st;
    bit         err;
    bit         par;
  } frame_t;
  frame_t rx_q[$];

  // Line decoder: watches tx like a UART receiver, one sample per clock.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (rst_n === 1'b1 && tx === 1'b0) begin
        frame_t           f;
        logic [NBITS-1:0] bits;
        bit               ab;
        f.st = cyc; f.err = 1'b0; f.par = 1'b0; ab = 1'b0; bits = '0;
        for (int b = 0; b < NBITS && !ab; b++) begin
          for (int k = 0; k < CPB && !ab; k++) begin
            if (rst_n !== 1'b1) ab = 1'b1;
            else begin
              if (k == 0) bits[b] = tx;
              else if (tx !== bits[b]) f.err = 1'b1;
              if (!(b == NBITS - 1 && k == CPB - 1)) begin @(posedge clk); #2; end
            end
          end
        end
        if (!ab) begin
          f.b = bits[8:1];
          if (bits[NBITS-1] !== 1'b1) f.err = 1'b1;
`ifdef AVR_SERIAL_TX_PARITY_EN
          f.par = bits[9];
`endif
          rx_q.push_back(f);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_byte(input logic [7:0] v);
    data = v; new_data = 1'b1;
    @(posedge clk); #1;
    new_data = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int bound);
    for (int t = 0; t < bound && rx_q.size() < n; t++) tick(1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    n_cmp++; if (tx !== 1'b1)     begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (ready !== 1'b1)  begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (count !== '0)    begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_single;
    int e;
    rx_q.delete();
    data = 8'hA5; new_data = 1'b1;
    @(posedge clk); #1;
    new_data = 1'b0;
    e = cyc;
    tick(1);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL single_tx_e1: got %b want 1", tx); end
    tick(1);
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL single_tx_e2: got %b want 0", tx); end
    while (cyc < e + FRAME) tick(1);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_end: got %b want 1", busy); end
    tick(1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_drop: got %b want 0", busy); end
    wait_frames(1, 20);
    n_cmp++;
    if (rx_q.size() != 1) begin
      n_bad++; $display("FAIL single_frames: got %0d want 1", rx_q.size());
    end else begin
      if (rx_q[0].b !== 8'hA5 || rx_q[0].err || rx_q[0].st != e + 2) begin
        n_bad++;
        $display("FAIL single_frame: got byte %h err %0d start %0d want byte a5 err 0 start %0d",
                 rx_q[0].b, rx_q[0].err, rx_q[0].st, e + 2);
      end
    end
  endtask

  task automatic test_full_block;
    bit bad_tx;
    rx_q.delete();
    block = 1'b1;
    tick(3);
    for (int i = 1; i <= 9; i++) begin
      n_cmp++;
      if (ready !== (i <= 8)) begin n_bad++; $display("FAIL full_ready_%0d: got %b want %b", i, ready, i <= 8); end
      push_byte(8'(i));
    end
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_count: got %0d want 8", count); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", ready); end
    bad_tx = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(1); if (tx !== 1'b1) bad_tx = 1'b1; end
    n_cmp++; if (bad_tx || rx_q.size() != 0) begin n_bad++; $display("FAIL full_blocked_tx: got frames %0d want 0", rx_q.size()); end
    block = 1'b0;
    wait_frames(8, 8 * FRAME + 40);
    n_cmp++;
    if (rx_q.size() != 8) begin
      n_bad++; $display("FAIL full_frames: got %0d want 8", rx_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (rx_q[i].b !== 8'(i + 1) || rx_q[i].err) begin
          n_bad++; $display("FAIL full_byte_%0d: got %h want %h", i, rx_q[i].b, 8'(i + 1));
        end
        if (i > 0) begin
          n_cmp++;
          if (rx_q[i].st - rx_q[i-1].st != FRAME) begin
            n_bad++; $display("FAIL full_spacing_%0d: got %0d want %0d", i, rx_q[i].st - rx_q[i-1].st, FRAME);
          end
        end
      end
    end
    tick(3);
    n_cmp++; if (busy !== 1'b0 || count !== '0) begin n_bad++; $display("FAIL full_drained: got busy %b count %0d want 0 0", busy, count); end
  endtask

  task automatic test_block_midframe;
    int b;
    rx_q.delete();
    push_byte(8'h3C);
    push_byte(8'hC3);
    tick(14);
    block = 1'b1;
    wait_frames(1, FRAME + 10);
    tick(30);
    n_cmp++;
    if (rx_q.size() != 1 || count !== 4'd1 || tx !== 1'b1) begin
      n_bad++; $display("FAIL mid_hold: got frames %0d count %0d tx %b want 1 1 1", rx_q.size(), count, tx);
    end
    block = 1'b0;
    b = cyc + 1;
    wait_frames(2, FRAME + 20);
    n_cmp++;
    if (rx_q.size() != 2) begin
      n_bad++; $display("FAIL mid_frames: got %0d want 2", rx_q.size());
    end else begin
      if (rx_q[0].b !== 8'h3C || rx_q[1].b !== 8'hC3 || rx_q[0].err || rx_q[1].err) begin
        n_bad++; $display("FAIL mid_bytes: got %h %h want 3c c3", rx_q[0].b, rx_q[1].b);
      end
      n_cmp++;
      if (rx_q[1].st - b < 1 || rx_q[1].st - b > 3) begin
        n_bad++; $display("FAIL mid_restart: got %0d cycles want 1..3", rx_q[1].st - b);
      end
    end
  endtask

  task automatic test_full_pop;
    logic [7:0] exp_q[$];
    int t;
    rx_q.delete();
    block = 1'b1;
    tick(3);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 254));
      exp_q.push_back(v);
      push_byte(v);
    end
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL pop_fill: got %0d want 8", count); end
    data = 8'hFF; new_data = 1'b1; block = 1'b0;
    for (t = 0; t < 10 && count === 4'd8; t++) tick(1);
    new_data = 1'b0;
    n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL pop_refuse: got %0d want 7", count); end
    wait_frames(8, 8 * FRAME + 60);
    tick(FRAME + 10);
    n_cmp++;
    if (rx_q.size() != 8) begin
      n_bad++; $display("FAIL pop_frames: got %0d want 8", rx_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (rx_q[i].b !== exp_q[i] || rx_q[i].err) begin
          n_bad++; $display("FAIL pop_byte_%0d: got %h want %h", i, rx_q[i].b, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int e;
    rx_q.delete();
    push_byte(8'h5A);
    e = cyc;
    push_byte(8'h81);
    while (cyc < e + 19) tick(1);
    rst_n = 1'b0;
    tick(1);
    n_cmp++;
    if (tx !== 1'b1 || count !== '0 || busy !== 1'b0 || ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_state: got tx %b count %0d busy %b ready %b want 1 0 0 1", tx, count, busy, ready);
    end
    rst_n = 1'b1;
    tick(3 * FRAME);
    n_cmp++;
    if (rx_q.size() != 0 || tx !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_quiet: got frames %0d tx %b want 0 1", rx_q.size(), tx);
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    rx_q.delete();
    for (int burst = 0; burst < 6; burst++) begin
      int n;
      n = $urandom_range(1, 8);
      block = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < n; i++) begin
        logic [7:0] v;
        v = 8'($urandom);
        exp_q.push_back(v);
        n_cmp++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL rand_ready_%0d_%0d: got %b want 1", burst, i, ready); end
        push_byte(v);
        tick($urandom_range(0, 5));
      end
      tick($urandom_range(0, 20));
      block = 1'b0;
      wait_frames(exp_q.size(), 9 * FRAME + 20);
      tick(4);
    end
    n_cmp++;
    if (rx_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL rand_frames: got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (rx_q[i].b !== exp_q[i] || rx_q[i].err) begin
          n_bad++; $display("FAIL rand_byte_%0d: got %h want %h", i, rx_q[i].b, exp_q[i]);
        end
`ifdef AVR_SERIAL_TX_PARITY_EN
        n_cmp++;
        if (rx_q[i].par !== ($countones(exp_q[i]) % 2 == 1)) begin
          n_bad++; $display("FAIL rand_par_%0d: got %b for byte %h", i, rx_q[i].par, exp_q[i]);
        end
`endif
      end
    end
  endtask

`ifdef AVR_SERIAL_TX_PARITY_EN
  task automatic test_parity;
    rx_q.delete();
    push_byte(8'h07);
    push_byte(8'h03);
    wait_frames(2, 2 * FRAME + 20);
    n_cmp++;
    if (rx_q.size() != 2) begin
      n_bad++; $display("FAIL par_frames: got %0d want 2", rx_q.size());
    end else begin
      n_cmp++;
      if (rx_q[0].par !== 1'b1 || rx_q[1].par !== 1'b0) begin
        n_bad++; $display("FAIL par_bits: got %b %b want 1 0", rx_q[0].par, rx_q[1].par);
      end
      n_cmp++;
      if (rx_q[1].st - rx_q[0].st != 44 || rx_q[0].b !== 8'h07 || rx_q[1].b !== 8'h03) begin
        n_bad++; $display("FAIL par_frame: got spacing %0d bytes %h %h want 44 07 03",
                          rx_q[1].st - rx_q[0].st, rx_q[0].b, rx_q[1].b);
      end
    end
    tick(10);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_full_block();
    test_block_midframe();
    test_full_pop();
    test_reset_mid();
    test_random();
`ifdef AVR_SERIAL_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
